// File: rtl/quant_eltwise_vec.sv
// quant_eltwise_vec -- quantized int8 element-wise MUL / SQDIFF over VECTOR_SIZE lanes.
//
// Per lane: a = in1 + input1_offset, b = in2 + input2_offset, P = a*b or (a-b)^2,
// then the usual fixed-point requantization (left shift, doubling high-mul, rounding
// right shift), output offset and clamp. Masked lanes output 8'h00.
//
// Pipeline: input capture, S1 offset add, S2 product + left shift, S3 high-mul,
// S4 rounding shift / offset / clamp into the output register. A beat accepted on
// edge N is visible after edge N+4. The whole pipeline stalls when valid_o && !ready_i.
//
// Ports:
//   clk, rst (async, active-low)        clock and reset
//   in_valid / in_ready                 input handshake
//   mode, lane_mask, input1, input2     per-beat operands (0 = MUL, 1 = SQDIFF)
//   input1_offset .. quantized_activation_max  per-beat quantization parameters
//   data_o / valid_o / ready_i          output handshake
//   beat_count                          delivered beats, wrapping
//   sat_count                           only with QUANT_ELTWISE_SAT_CNT_EN: clamped unmasked lanes
//
// Optional feature macro: QUANT_ELTWISE_SAT_CNT_EN

module quant_eltwise_vec #(
  parameter int VECTOR_SIZE = 8,
  parameter int OUT_CNT_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     mode,
  input  logic [VECTOR_SIZE-1:0]   lane_mask,
  input  logic [8*VECTOR_SIZE-1:0] input1,
  input  logic [8*VECTOR_SIZE-1:0] input2,
  input  logic signed [31:0]       input1_offset,
  input  logic signed [31:0]       input2_offset,
  input  logic signed [31:0]       output_offset,
  input  logic signed [31:0]       output_multiplier,
  input  logic signed [31:0]       output_shift,
  input  logic signed [31:0]       quantized_activation_min,
  input  logic signed [31:0]       quantized_activation_max,
  output logic [8*VECTOR_SIZE-1:0] data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [OUT_CNT_W-1:0]     beat_count
`ifdef QUANT_ELTWISE_SAT_CNT_EN
  ,
  output logic [31:0]              sat_count
`endif
);

  // Parameters still needed by the final stage, carried alongside each beat.
  typedef struct packed {
    logic [VECTOR_SIZE-1:0] mask;
    logic signed [31:0]     shift;
    logic signed [31:0]     ooff;
    logic signed [31:0]     amin;
    logic signed [31:0]     amax;
  } tail_t;

  logic w_stall;
  logic w_adv;

  logic r_v0, r_v1, r_v2, r_v3;

  logic [8*VECTOR_SIZE-1:0] r_s0_in1, r_s0_in2;
  logic signed [31:0]       r_s0_off1, r_s0_off2, r_s0_mult;
  logic                     r_s0_mode;
  tail_t                    r_s0_q;

  logic signed [31:0] r_s1_a [VECTOR_SIZE];
  logic signed [31:0] r_s1_b [VECTOR_SIZE];
  logic               r_s1_mode;
  logic signed [31:0] r_s1_mult;
  tail_t              r_s1_q;

  logic signed [31:0] r_s2_l [VECTOR_SIZE];
  logic signed [31:0] r_s2_mult;
  tail_t              r_s2_q;

  logic signed [31:0] r_s3_h [VECTOR_SIZE];
  tail_t              r_s3_q;

  logic signed [31:0] w_a    [VECTOR_SIZE];
  logic signed [31:0] w_b    [VECTOR_SIZE];
  logic signed [31:0] w_p    [VECTOR_SIZE];
  logic signed [31:0] w_l    [VECTOR_SIZE];
  logic signed [63:0] w_prod [VECTOR_SIZE];
  logic signed [31:0] w_h    [VECTOR_SIZE];
  logic [4:0]         w_e;
  logic [31:0]        w_rmask;
  logic [31:0]        w_rem  [VECTOR_SIZE];
  logic [31:0]        w_thr  [VECTOR_SIZE];
  logic signed [31:0] w_r    [VECTOR_SIZE];
  logic signed [32:0] w_sum  [VECTOR_SIZE];
  logic [8*VECTOR_SIZE-1:0] w_data;

`ifdef QUANT_ELTWISE_SAT_CNT_EN
  logic [VECTOR_SIZE-1:0] w_sat;
  logic [VECTOR_SIZE-1:0] r_sat_lanes;
  logic [31:0]            w_sat_inc;
`endif

  assign w_stall  = valid_o & ~ready_i;
  assign w_adv    = ~w_stall;
  assign in_ready = w_adv;

  // S1: sign-extend each int8 lane and add its input offset.
  always_comb begin
    for (int i = 0; i < VECTOR_SIZE; i++) begin
      w_a[i] = 32'($signed(r_s0_in1[8*i +: 8])) + r_s0_off1;
      w_b[i] = 32'($signed(r_s0_in2[8*i +: 8])) + r_s0_off2;
    end
  end

  // S2: product or squared difference, then the positive part of the shift.
  always_comb begin
    for (int i = 0; i < VECTOR_SIZE; i++) begin
      if (r_s1_mode) begin
        w_p[i] = (r_s1_a[i] - r_s1_b[i]) * (r_s1_a[i] - r_s1_b[i]);
      end else begin
        w_p[i] = r_s1_a[i] * r_s1_b[i];
      end
      // Shifting 32 or more places clears the value.
      if (r_s1_q.shift > 32'sd31) begin
        w_l[i] = 32'sd0;
      end else if (r_s1_q.shift > 32'sd0) begin
        w_l[i] = w_p[i] << r_s1_q.shift[4:0];
      end else begin
        w_l[i] = w_p[i];
      end
    end
  end

  // S3: doubling high-mul; the only overflowing operand pair saturates to INT32_MAX.
  always_comb begin
    for (int i = 0; i < VECTOR_SIZE; i++) begin
      w_prod[i] = 64'(r_s2_l[i]) * 64'(r_s2_mult);
      if ((r_s2_l[i] == 32'sh8000_0000) && (r_s2_mult == 32'sh8000_0000)) begin
        w_h[i] = 32'sh7FFF_FFFF;
      end else begin
        w_h[i] = 32'((w_prod[i] + 64'sh4000_0000) >>> 31);
      end
    end
  end

  // S4: right-shift exponent, capped at 31 so the rounding mask stays in 32 bits.
  always_comb begin
    if (r_s3_q.shift < -32'sd31) begin
      w_e = 5'd31;
    end else if (r_s3_q.shift < 32'sd0) begin
      w_e = 5'(-r_s3_q.shift);
    end else begin
      w_e = 5'd0;
    end
    w_rmask = (32'd1 << w_e) - 32'd1;
  end

  // S4: rounding divide by power of two, output offset, clamp and lane mask.
  always_comb begin
    w_data = '0;
`ifdef QUANT_ELTWISE_SAT_CNT_EN
    w_sat  = '0;
`endif
    for (int i = 0; i < VECTOR_SIZE; i++) begin
      w_rem[i] = r_s3_h[i] & w_rmask;
      // Negative values get a threshold one higher, which rounds halves away from zero.
      w_thr[i] = (w_rmask >> 1) + (r_s3_h[i][31] ? 32'd1 : 32'd0);
      w_r[i]   = (r_s3_h[i] >>> w_e) + ((w_rem[i] > w_thr[i]) ? 32'sd1 : 32'sd0);
      // 33-bit sum so an offset overflow still clamps correctly.
      w_sum[i] = 33'(w_r[i]) + 33'(r_s3_q.ooff);
      if (!r_s3_q.mask[i]) begin
        w_data[8*i +: 8] = 8'h00;
      end else if (w_sum[i] > 33'(r_s3_q.amax)) begin
        w_data[8*i +: 8] = r_s3_q.amax[7:0];
      end else if (w_sum[i] < 33'(r_s3_q.amin)) begin
        w_data[8*i +: 8] = r_s3_q.amin[7:0];
      end else begin
        w_data[8*i +: 8] = w_sum[i][7:0];
      end
`ifdef QUANT_ELTWISE_SAT_CNT_EN
      w_sat[i] = r_s3_q.mask[i] &
                 ((w_sum[i] > 33'(r_s3_q.amax)) | (w_sum[i] < 33'(r_s3_q.amin)));
`endif
    end
  end

  // Stage valid flags; the whole pipeline advances together unless the output stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v0    <= 1'b0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      valid_o <= 1'b0;
    end else if (w_adv) begin
      r_v0    <= in_valid;
      r_v1    <= r_v0;
      r_v2    <= r_v1;
      r_v3    <= r_v2;
      valid_o <= r_v3;
    end
  end

  // Pipeline data registers, including the per-beat parameter snapshot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s0_in1  <= '0;
      r_s0_in2  <= '0;
      r_s0_off1 <= 32'sd0;
      r_s0_off2 <= 32'sd0;
      r_s0_mult <= 32'sd0;
      r_s0_mode <= 1'b0;
      r_s0_q    <= '0;
      r_s1_mode <= 1'b0;
      r_s1_mult <= 32'sd0;
      r_s1_q    <= '0;
      r_s2_mult <= 32'sd0;
      r_s2_q    <= '0;
      r_s3_q    <= '0;
      data_o    <= '0;
      for (int i = 0; i < VECTOR_SIZE; i++) begin
        r_s1_a[i] <= 32'sd0;
        r_s1_b[i] <= 32'sd0;
        r_s2_l[i] <= 32'sd0;
        r_s3_h[i] <= 32'sd0;
      end
    end else if (w_adv) begin
      r_s0_in1  <= input1;
      r_s0_in2  <= input2;
      r_s0_off1 <= input1_offset;
      r_s0_off2 <= input2_offset;
      r_s0_mult <= output_multiplier;
      r_s0_mode <= mode;
      r_s0_q    <= '{mask: lane_mask, shift: output_shift, ooff: output_offset,
                     amin: quantized_activation_min, amax: quantized_activation_max};
      r_s1_mode <= r_s0_mode;
      r_s1_mult <= r_s0_mult;
      r_s1_q    <= r_s0_q;
      r_s2_mult <= r_s1_mult;
      r_s2_q    <= r_s1_q;
      r_s3_q    <= r_s2_q;
      data_o    <= w_data;
      for (int i = 0; i < VECTOR_SIZE; i++) begin
        r_s1_a[i] <= w_a[i];
        r_s1_b[i] <= w_b[i];
        r_s2_l[i] <= w_l[i];
        r_s3_h[i] <= w_h[i];
      end
    end
  end

  // Delivered-beat counter, wrapping naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_count <= '0;
    end else if (valid_o && ready_i) begin
      beat_count <= beat_count + OUT_CNT_W'(1);
    end
  end

`ifdef QUANT_ELTWISE_SAT_CNT_EN
  // Number of clamped lanes in the beat currently held in the output register.
  always_comb begin
    w_sat_inc = 32'd0;
    for (int i = 0; i < VECTOR_SIZE; i++) begin
      w_sat_inc = w_sat_inc + 32'(r_sat_lanes[i]);
    end
  end

  // Saturation flags travel with data_o; the count updates when that beat is delivered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sat_lanes <= '0;
      sat_count   <= 32'd0;
    end else begin
      if (w_adv) begin
        r_sat_lanes <= w_sat;
      end
      if (valid_o && ready_i) begin
        sat_count <= sat_count + w_sat_inc;
      end
    end
  end
`endif

endmodule
